bus8088_mem_wait: RTL and testbench

Parametrised 8088-style bus memory/IO peripheral with registered address latch, base/size address decode and programmable wait-state insertion via READY. It sits on the minimum-mode 8088 bus alongside other peripherals. It answers only in its configured IOM space and address window, and it performs exactly one array access per bus cycle. A sticky error flag records malformed cycles (RD and WR both asserted).

---
 rtl/bus8088_mem_wait.sv | 136 +++++++++++++
 tb/tb_bus8088_mem_wait.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus8088_mem_wait.sv
// 8088 minimum-mode bus memory/IO peripheral.
// Latches the address in T1 on a window hit, waits for a strobe in T2,
// inserts WAIT_STATES Tw cycles (READY low), then performs a single
// array read (T3_R) or write (T3_W) before returning to idle via T4.
module bus8088_mem_wait #(
    parameter int                    ADDR_WIDTH  = 20,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH_LOG2  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic                  SPACE       = 1'b0,
    parameter int                    WAIT_STATES = 0,
    parameter string                 INIT_FILE   = ""
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ALE,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  IOM,
    input  logic                  RD,
    input  logic                  WR,
    input  logic                  sel,
    inout  wire  [DATA_WIDTH-1:0] Data,
    output logic                  READY,
    output logic                  err
);

    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [ADDR_WIDTH:0] WIN_LO  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] WIN_LEN = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          WAIT_LD = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        T1   = 3'd0,
        T2   = 3'd1,
        TW   = 3'd2,
        T3_R = 3'd3,
        T3_W = 3'd4,
        T4   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic                  dir_q, dir_d;   // 1 = write
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   offset;
    logic                  hit;
    logic                  rd_en;
    logic                  wr_en;

    // Window decode: one widened subtraction; addresses below the base borrow
    // into the top bit and so land outside [0, DEPTH), and there is no wrap.
    always_comb begin
        offset = {1'b0, Address} - WIN_LO;
        hit    = ALE & sel & (IOM == SPACE) & (offset < WIN_LEN);
    end

    // State and cycle-context registers; async reset returns to idle at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= T1;
            cnt_q   <= '0;
            addr_q  <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: address latch, direction decision and wait countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dir_d   = dir_q;
        err_d   = err_q;
        unique case (state_q)
            T1: begin
                if (hit) begin
                    addr_d  = offset[DEPTH_LOG2-1:0];
                    state_d = T2;
                end
            end
            T2: begin
                if (!RD && !WR) begin
                    err_d   = 1'b1;
                    state_d = T4;
                end else if (!RD || !WR) begin
                    dir_d = !WR;
                    if (WAIT_STATES > 0) begin
                        cnt_d   = WAIT_LD;
                        state_d = TW;
                    end else begin
                        state_d = !WR ? T3_W : T3_R;
                    end
                end
            end
            TW: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = dir_q ? T3_W : T3_R;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            T3_R:    state_d = T4;
            T3_W:    state_d = T4;
            T4:      state_d = T1;
            default: state_d = T1;
        endcase
    end

    // Outputs decoded from the current state only.
    always_comb begin
        READY = (state_q != TW);
        rd_en = (state_q == T3_R) && !RD;
        wr_en = (state_q == T3_W) && !WR;
        err   = err_q;
    end

    // Array write on the edge that leaves T3_W, only if WR is still low.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[addr_q] <= Data;
    end

    assign Data = rd_en ? mem[addr_q] : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus8088_mem_wait.sv
// Bench: four peripherals share one bus, each with its own board select.
//   0: memory, base 0x00000, 64K words, no waits
//   1: memory, base 0x00000, 256 words, 3 waits
//   2: memory, base 0x80000, 16 words, 2 waits
//   3: IO,     base 0x00000, 256 words, 1 wait
// The released data bus is pulled high, so high-Z reads back as all ones.
module tb_bus8088_mem_wait;

    localparam int AW = 20;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ALE;
    logic [AW-1:0] Address;
    logic          IOM;
    logic          RD;
    logic          WR;
    logic [3:0]    sel_v;
    logic          drv_en;
    logic [DW-1:0] dout;
    tri1  [DW-1:0] Data;
    logic [3:0]    rdy;
    logic [3:0]    errv;

    assign Data = drv_en ? dout : {DW{1'bz}};

    always #5 CLK = ~CLK;

    bus8088_mem_wait #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(16), .BASE_ADDR(20'h00000),
                       .SPACE(1'b0), .WAIT_STATES(0), .INIT_FILE("")) u_m0 (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .Address(Address), .IOM(IOM), .RD(RD), .WR(WR),
        .sel(sel_v[0]), .Data(Data), .READY(rdy[0]), .err(errv[0]));

    bus8088_mem_wait #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(8), .BASE_ADDR(20'h00000),
                       .SPACE(1'b0), .WAIT_STATES(3), .INIT_FILE("")) u_m3 (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .Address(Address), .IOM(IOM), .RD(RD), .WR(WR),
        .sel(sel_v[1]), .Data(Data), .READY(rdy[1]), .err(errv[1]));

    bus8088_mem_wait #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(4), .BASE_ADDR(20'h80000),
                       .SPACE(1'b0), .WAIT_STATES(2), .INIT_FILE("")) u_mb (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .Address(Address), .IOM(IOM), .RD(RD), .WR(WR),
        .sel(sel_v[2]), .Data(Data), .READY(rdy[2]), .err(errv[2]));

    bus8088_mem_wait #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(8), .BASE_ADDR(20'h00000),
                       .SPACE(1'b1), .WAIT_STATES(1), .INIT_FILE("")) u_io (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .Address(Address), .IOM(IOM), .RD(RD), .WR(WR),
        .sel(sel_v[3]), .Data(Data), .READY(rdy[3]), .err(errv[3]));

    int cfg_base  [4] = '{32'h00000, 32'h00000, 32'h80000, 32'h00000};
    int cfg_size  [4] = '{65536, 256, 16, 256};
    int cfg_space [4] = '{0, 0, 0, 1};
    int cfg_wait  [4] = '{0, 3, 2, 1};

    // Reference contents, keyed by instance * 2**20 + word index.
    logic [7:0] model [int];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input int i, input logic [3:0] s, input int a, input bit iom);
        return s[i] && (iom == cfg_space[i][0]) && (a >= cfg_base[i]) && (a < cfg_base[i] + cfg_size[i]);
    endfunction

    // One complete bus cycle as a master would run it, with the expected
    // READY/Data pattern derived from which (if any) peripheral should answer.
    task automatic run_cycle(input logic [3:0] s, input int a, input bit iom, input bit wr,
                             input logic [7:0] wd, input int extra, input string tag);
        int         hi;
        int         w;
        int         key;
        bit         known;
        logic [7:0] ev;
        logic [3:0] exp_rdy;
        hi  = -1;
        key = 0;
        for (int i = 0; i < 4; i++) if (model_hit(i, s, a, iom)) hi = i;
        w       = (hi >= 0) ? cfg_wait[hi] : 0;
        exp_rdy = (hi >= 0) ? (4'hF & ~(4'b0001 << hi)) : 4'hF;
        if (hi >= 0) key = hi * (1 << 20) + (a - cfg_base[hi]);
        known = (hi < 0) || model.exists(key);
        ev    = (hi >= 0 && known) ? model[key] : 8'hFF;

        @(posedge CLK); #1;
        ALE = 1'b1; Address = a[AW-1:0]; IOM = iom; sel_v = s; RD = 1'b1; WR = 1'b1;
        @(posedge CLK); #1;
        ALE = 1'b0; Address = AW'($urandom); IOM = 1'($urandom); sel_v = 4'($urandom);
        for (int e = 0; e < extra; e++) begin
            @(negedge CLK);
            check({tag, " t2 idle ready"}, 32'(rdy), 32'hF);
            check({tag, " t2 idle data"}, 32'(Data), 32'hFF);
            @(posedge CLK); #1;
        end
        if (wr) begin
            WR = 1'b0; drv_en = 1'b1; dout = wd;
        end else begin
            RD = 1'b0;
        end
        @(negedge CLK);
        check({tag, " t2 ready"}, 32'(rdy), 32'hF);
        if (!wr) check({tag, " t2 data"}, 32'(Data), 32'hFF);
        for (int k = 0; k < w; k++) begin
            @(posedge CLK); @(negedge CLK);
            check({tag, " tw ready"}, 32'(rdy), 32'(exp_rdy));
            if (!wr) check({tag, " tw data"}, 32'(Data), 32'hFF);
        end
        @(posedge CLK); @(negedge CLK);
        check({tag, " t3 ready"}, 32'(rdy), 32'hF);
        if (!wr && known) check({tag, " t3 data"}, 32'(Data), 32'(ev));
        @(posedge CLK); @(negedge CLK);
        check({tag, " t4 ready"}, 32'(rdy), 32'hF);
        if (!wr) check({tag, " t4 data"}, 32'(Data), 32'hFF);
        RD = 1'b1; WR = 1'b1; drv_en = 1'b0;
        if (wr && hi >= 0) model[key] = wd;
    endtask

    initial begin
        RESET = 1'b1; ALE = 1'b0; Address = '0; IOM = 1'b0; RD = 1'b1; WR = 1'b1;
        sel_v = 4'h0; drv_en = 1'b0; dout = '0;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset ready", 32'(rdy), 32'hF);
        check("reset err", 32'(errv), 32'h0);
        check("reset data", 32'(Data), 32'hFF);
        RESET = 1'b0;

        // No-wait memory: write then read back, 4-clock cycles
        run_cycle(4'b0001, 32'h00010, 1'b0, 1'b1, 8'hA5, 0, "m0 wr 10");
        run_cycle(4'b0001, 32'h00010, 1'b0, 1'b0, 8'h00, 0, "m0 rd 10");

        // Three wait states
        run_cycle(4'b0010, 32'h00002, 1'b0, 1'b1, 8'h3C, 0, "m3 wr 02");
        run_cycle(4'b0010, 32'h00002, 1'b0, 1'b0, 8'h00, 1, "m3 rd 02");

        // Window edges on the high-base instance
        run_cycle(4'b0100, 32'h80000, 1'b0, 1'b1, 8'h12, 0, "mb wr 80000");
        run_cycle(4'b0100, 32'h80010, 1'b0, 1'b1, 8'hEE, 0, "mb wr 80010 miss");
        run_cycle(4'b0100, 32'h7FFFF, 1'b0, 1'b1, 8'hDD, 0, "mb wr 7ffff miss");
        run_cycle(4'b0100, 32'h8000F, 1'b0, 1'b1, 8'h77, 0, "mb wr 8000f");
        run_cycle(4'b0100, 32'h80010, 1'b0, 1'b0, 8'h00, 0, "mb rd 80010 miss");
        run_cycle(4'b0100, 32'h80000, 1'b0, 1'b0, 8'h00, 0, "mb rd 80000");
        run_cycle(4'b0100, 32'h8000F, 1'b0, 1'b0, 8'h00, 0, "mb rd 8000f");

        // IO space instance, with the memory instance also selected
        run_cycle(4'b0001, 32'h00020, 1'b0, 1'b1, 8'h44, 0, "m0 wr 20");
        run_cycle(4'b1000, 32'h00020, 1'b0, 1'b1, 8'h99, 0, "io wr iom0 miss");
        run_cycle(4'b1001, 32'h00020, 1'b1, 1'b1, 8'h5A, 0, "io wr 20");
        run_cycle(4'b1001, 32'h00020, 1'b1, 1'b0, 8'h00, 0, "io rd 20");
        run_cycle(4'b0001, 32'h00020, 1'b0, 1'b0, 8'h00, 0, "m0 rd 20");

        // Both strobes low in T2
        @(posedge CLK); #1;
        ALE = 1'b1; Address = 20'h00010; IOM = 1'b0; sel_v = 4'b0001;
        @(posedge CLK); #1;
        ALE = 1'b0; RD = 1'b0; WR = 1'b0;
        @(negedge CLK);
        check("err before", 32'(errv), 32'h0);
        @(posedge CLK); @(negedge CLK);
        check("err set", 32'(errv), 32'h1);
        check("err t4 ready", 32'(rdy), 32'hF);
        check("err t4 data", 32'(Data), 32'hFF);
        RD = 1'b1; WR = 1'b1;
        run_cycle(4'b0001, 32'h00010, 1'b0, 1'b0, 8'h00, 0, "m0 rd after err");
        check("err sticky", 32'(errv), 32'h1);

        // Reset during the wait states of a write
        run_cycle(4'b0010, 32'h00040, 1'b0, 1'b1, 8'h11, 0, "m3 wr 40");
        @(posedge CLK); #1;
        ALE = 1'b1; Address = 20'h00040; IOM = 1'b0; sel_v = 4'b0010;
        @(posedge CLK); #1;
        ALE = 1'b0; WR = 1'b0; drv_en = 1'b1; dout = 8'hFF;
        @(posedge CLK); @(negedge CLK);
        check("rst pre tw ready", 32'(rdy), 32'hD);
        #1 RESET = 1'b1;
        #1;
        check("rst async ready", 32'(rdy), 32'hF);
        check("rst async err", 32'(errv), 32'h0);
        drv_en = 1'b0;
        #1;
        check("rst async data", 32'(Data), 32'hFF);
        @(posedge CLK); @(posedge CLK); #1;
        WR = 1'b1; RESET = 1'b0;
        run_cycle(4'b0010, 32'h00040, 1'b0, 1'b0, 8'h00, 0, "m3 rd 40 after rst");

        // Randomized cycles against the reference model
        for (int n = 0; n < 60; n++) begin
            int         inst;
            int         a;
            int         span;
            logic [3:0] s;
            bit         iom;
            inst = $urandom_range(0, 3);
            s    = ($urandom_range(0, 9) == 0) ? 4'b0000 : (4'b0001 << inst);
            span = (cfg_size[inst] < 32) ? cfg_size[inst] : 32;
            case ($urandom_range(0, 9))
                0:       a = (cfg_base[inst] - 1) & 32'hFFFFF;
                1:       a = (cfg_base[inst] + cfg_size[inst]) & 32'hFFFFF;
                2:       a = $urandom_range(0, 32'hFFFFF);
                default: a = cfg_base[inst] + $urandom_range(0, span - 1);
            endcase
            iom = ($urandom_range(0, 5) == 0) ? !cfg_space[inst][0] : cfg_space[inst][0];
            run_cycle(s, a, iom, 1'($urandom), 8'($urandom), $urandom_range(0, 2), "rand");
        end

        @(negedge CLK);
        check("final err", 32'(errv), 32'h0);
        check("final ready", 32'(rdy), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
